key_debounce: RTL and testbench



---
 rtl/key_debounce.sv | 141 ++++++++++++++
 tb/tb_key_debounce.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Push-button conditioner: synchronises a raw pad, debounces it and emits clean level plus
// single-cycle press, release and long-press pulses for the downstream LED logic.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

  localparam logic [DebW-1:0]  DebOne   = DebW'(1);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(HOLD_CYCLES);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic             PadReleased = KEY_ACTIVE_LOW;

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StPressWait = 2'd1;
  localparam logic [1:0] StPressed   = 2'd2;
  localparam logic [1:0] StRelWait   = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  logic [1:0]       state_q, state_d;
  logic [DebW-1:0]  deb_q, deb_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;

  // Chain reloads with the released pad level so a key held through reset counts as a new press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{PadReleased}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1] ^ PadReleased;

  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    hold_d    = hold_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;

    // Hold timing runs through release bounces; saturation makes key_long fire once per press.
    if (state_q == StPressed || state_q == StRelWait) begin
      if (hold_q < HoldMax) hold_d = hold_q + 1'b1;
      if (hold_q == HoldLast) long_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (s) begin
          state_d = StPressWait;
          deb_d   = DebOne;
        end
      end
      StPressWait: begin
        if (!s) begin
          state_d = StIdle;
          deb_d   = '0;
        end else if (deb_q == DebLast) begin
          state_d = StPressed;
          deb_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
          hold_d  = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      StPressed: begin
        if (!s) begin
          state_d = StRelWait;
          deb_d   = DebOne;
        end
      end
      StRelWait: begin
        if (s) begin
          state_d = StPressed;
          deb_d   = '0;
        end else if (deb_q == DebLast) begin
          state_d   = StIdle;
          deb_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        deb_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      deb_q     <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_q     <= deb_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, SYNC_STAGES=2, active-low.
// Edge e counts from the edge after which the scenario's first pad change is driven.
module tb_key_debounce;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_in = 1'b1;
  logic key_level, key_press, key_release, key_long;

  int checks = 0;
  int errors = 0;

  key_debounce #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .SYNC_STAGES    (2),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    rst    = 1'b1;
    key_in = 1'b1;
    repeat (3) tick();
    obs = {key_level, key_press, key_release, key_long};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: got %b expected 0000", obs);
    end
    rst = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      tick();
      obs = {key_level, key_press, key_release, key_long};
      checks++;
      if (obs !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle e=%0d: got %b expected 0000", e, obs);
      end
    end
  endtask

  task automatic test_press();
    logic [3:0] obs, exp;
    tick();
    key_in = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      obs = {key_level, key_press, key_release, key_long};
      exp = {(e >= 6 && e < 18), (e == 6), (e == 18), 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL press e=%0d: got %b expected %b", e, obs, exp);
      end
      if (e == 12) key_in = 1'b1;
    end
  endtask

  task automatic test_glitch();
    logic [3:0] obs;
    tick();
    key_in = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      obs = {key_level, key_press, key_release, key_long};
      checks++;
      if (obs !== 4'b0000) begin
        errors++;
        $display("FAIL glitch e=%0d: got %b expected 0000", e, obs);
      end
      key_in = !(e == 2 || e == 3 || e == 5 || e == 6 || e == 7);
    end
  endtask

  // bounce=1 adds a 2-cycle pad-high blip while held; expectations must not move.
  task automatic test_long_press(input bit bounce);
    logic [3:0] obs, exp;
    tick();
    key_in = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      obs = {key_level, key_press, key_release, key_long};
      exp = {(e >= 6 && e < 36), (e == 6), (e == 36), (e == 26)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s e=%0d: got %b expected %b", bounce ? "bounce" : "long_press", e, obs,
                 exp);
      end
      if (e == 30) key_in = 1'b1;
      if (bounce && e == 10) key_in = 1'b1;
      if (bounce && e == 12) key_in = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] obs, exp;
    tick();
    key_in = 1'b0;
    for (int e = 1; e <= 34; e++) begin
      tick();
      obs = {key_level, key_press, key_release, key_long};
      exp = {((e >= 12 && e < 17) || (e >= 23 && e < 31)), (e == 12 || e == 23), (e == 31),
             1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_mid e=%0d: got %b expected %b", e, obs, exp);
      end
      if (e == 4)  rst = 1'b1;
      if (e == 6)  rst = 1'b0;
      if (e == 16) rst = 1'b1;
      if (e == 17) rst = 1'b0;
      if (e == 25) key_in = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_long_press(1'b0);
    test_long_press(1'b1);
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
